// File: rtl/parking_pkg.sv
// Shared definitions for the parking-space timer.
// Holds the per-space FSM state encoding and the default terminal count
// (one hour minus one second).
package parking_pkg;

    typedef enum logic [1:0] {
        VACANT   = 2'd0,
        OCCUPIED = 2'd1,
        HOLD     = 2'd2
    } space_state_t;

    localparam int unsigned DEFAULT_MAX_SEC = 3599;

endpackage

// File: rtl/space_timer_ch.sv
// One parking-space channel: VACANT/OCCUPIED/HOLD FSM, seconds counter and
// optional sticky overflow flag.
// Config macro: MULTI_SPACE_TIMER_OVF_EN enables the overflow flag; when it is
// undefined ovf is tied to 0.
// Ports:
//   clk_1Hz    - 1 Hz clock, rising edge
//   rst        - asynchronous active-high reset
//   parked     - vehicle present in this space
//   clr        - host acknowledge/clear, honoured only in HOLD
//   sec_count  - seconds occupied (registered, frozen in HOLD)
//   done       - high while in HOLD (registered)
//   ovf        - sticky overflow flag (registered)
//   occ_nxt_c  - combinational: next state is OCCUPIED
module space_timer_ch
    import parking_pkg::*;
#(
    parameter int unsigned CNT_W    = 12,
    parameter int unsigned MAX_SEC  = DEFAULT_MAX_SEC,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clk_1Hz,
    input  logic             rst,
    input  logic             parked,
    input  logic             clr,
    output logic [CNT_W-1:0] sec_count,
    output logic             done,
    output logic             ovf,
    output logic             occ_nxt_c
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_SEC);

    space_state_t state;
    logic         at_max;

    assign at_max = (sec_count == MAX_C);

    // FSM, counter and done flag
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state     <= VACANT;
            sec_count <= '0;
            done      <= 1'b0;
        end else begin
            case (state)
                VACANT: begin
                    sec_count <= '0;
                    if (parked) begin
                        state <= OCCUPIED;
                    end
                end
                OCCUPIED: begin
                    if (parked) begin
                        if (at_max) begin
                            sec_count <= (SATURATE != 0) ? MAX_C : '0;
                        end else begin
                            sec_count <= sec_count + CNT_W'(1);
                        end
                    end else begin
                        // departure: freeze the count, no increment this edge
                        state <= HOLD;
                        done  <= 1'b1;
                    end
                end
                HOLD: begin
                    // re-arrival without clr is ignored; clr+parked re-arms directly
                    if (clr) begin
                        state     <= parked ? OCCUPIED : VACANT;
                        sec_count <= '0;
                        done      <= 1'b0;
                    end
                end
                default: begin
                    state     <= VACANT;
                    sec_count <= '0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // Next-state-is-OCCUPIED flag feeding the top-level popcount
    always_comb begin
        occ_nxt_c = 1'b0;
        case (state)
            VACANT:   occ_nxt_c = parked;
            OCCUPIED: occ_nxt_c = parked;
            HOLD:     occ_nxt_c = clr & parked;
            default:  occ_nxt_c = 1'b0;
        endcase
    end

`ifdef MULTI_SPACE_TIMER_OVF_EN
    // Sticky overflow: set when a count at MAX_SEC takes another increment
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if ((state == OCCUPIED) && parked && at_max) begin
            ovf <= 1'b1;
        end else if ((state == HOLD) && clr) begin
            ovf <= 1'b0;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/multi_space_timer.sv
// Multi-space parking timer: NUM_SPACES independent space_timer_ch channels
// plus a registered count of spaces currently OCCUPIED.
// Config macro: MULTI_SPACE_TIMER_OVF_EN (per-space sticky overflow flags).
// Ports:
//   clk_1Hz      - 1 Hz clock, rising edge
//   rst          - asynchronous active-high reset
//   parked       - per-space vehicle present
//   clr          - per-space host clear (effective in HOLD only)
//   sec_count    - packed counters, space i at [i*CNT_W +: CNT_W]
//   done         - per-space HOLD indicator
//   ovf          - per-space sticky overflow
//   occupied_cnt - number of spaces in OCCUPIED
module multi_space_timer
    import parking_pkg::*;
#(
    parameter int unsigned NUM_SPACES = 4,
    parameter int unsigned CNT_W      = 12,
    parameter int unsigned MAX_SEC    = DEFAULT_MAX_SEC,
    parameter int unsigned SATURATE   = 0
) (
    input  logic                              clk_1Hz,
    input  logic                              rst,
    input  logic [NUM_SPACES-1:0]             parked,
    input  logic [NUM_SPACES-1:0]             clr,
    output logic [NUM_SPACES*CNT_W-1:0]       sec_count,
    output logic [NUM_SPACES-1:0]             done,
    output logic [NUM_SPACES-1:0]             ovf,
    output logic [$clog2(NUM_SPACES+1)-1:0]   occupied_cnt
);

    localparam int unsigned OCC_W = $clog2(NUM_SPACES + 1);

    logic [NUM_SPACES-1:0] occ_nxt;
    logic [OCC_W-1:0]      occ_sum;

    // Per-space channels
    for (genvar g = 0; g < NUM_SPACES; g++) begin : g_ch
        space_timer_ch #(
            .CNT_W    (CNT_W),
            .MAX_SEC  (MAX_SEC),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk_1Hz   (clk_1Hz),
            .rst       (rst),
            .parked    (parked[g]),
            .clr       (clr[g]),
            .sec_count (sec_count[g*CNT_W +: CNT_W]),
            .done      (done[g]),
            .ovf       (ovf[g]),
            .occ_nxt_c (occ_nxt[g])
        );
    end

    // Popcount of next-state OCCUPIED, so the register matches the FSMs' new state
    always_comb begin
        occ_sum = '0;
        for (int i = 0; i < NUM_SPACES; i++) begin
            occ_sum = occ_sum + OCC_W'(occ_nxt[i]);
        end
    end

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            occupied_cnt <= '0;
        end else begin
            occupied_cnt <= occ_sum;
        end
    end

endmodule

// File: tb/tb_multi_space_timer.sv
// Bench for multi_space_timer: three instances (default wide counter, MAX_SEC=5
// wrapping, MAX_SEC=5 saturating) checked against a behavioural model, plus
// explicit table and hand-written sequences.
module tb_multi_space_timer;

`ifdef MULTI_SPACE_TIMER_OVF_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic        clk_1Hz;
    logic        rst;
    logic [3:0]  pk [3];
    logic [3:0]  cl [3];
    logic [47:0] sc0;
    logic [11:0] sc_w;
    logic [11:0] sc_s;
    logic [3:0]  dn [3];
    logic [3:0]  ov [3];
    logic [2:0]  oc [3];

    int n_tests = 0;
    int n_fail  = 0;

    // model: 0 = vacant, 1 = occupied, 2 = hold
    int m_st  [3][4];
    int m_cnt [3][4];
    bit m_ovf [3][4];

    multi_space_timer u_dut0 (
        .clk_1Hz(clk_1Hz), .rst(rst), .parked(pk[0]), .clr(cl[0]),
        .sec_count(sc0), .done(dn[0]), .ovf(ov[0]), .occupied_cnt(oc[0])
    );

    multi_space_timer #(.NUM_SPACES(4), .CNT_W(3), .MAX_SEC(5), .SATURATE(0)) u_dutw (
        .clk_1Hz(clk_1Hz), .rst(rst), .parked(pk[1]), .clr(cl[1]),
        .sec_count(sc_w), .done(dn[1]), .ovf(ov[1]), .occupied_cnt(oc[1])
    );

    multi_space_timer #(.NUM_SPACES(4), .CNT_W(3), .MAX_SEC(5), .SATURATE(1)) u_duts (
        .clk_1Hz(clk_1Hz), .rst(rst), .parked(pk[2]), .clr(cl[2]),
        .sec_count(sc_s), .done(dn[2]), .ovf(ov[2]), .occupied_cnt(oc[2])
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    function automatic int max_of(int d);
        return (d == 0) ? 3599 : 5;
    endfunction

    function automatic int get_cnt(int d, int i);
        case (d)
            0:       return int'(sc0[i*12 +: 12]);
            1:       return int'(sc_w[i*3 +: 3]);
            default: return int'(sc_s[i*3 +: 3]);
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 4; i++) begin
                m_st[d][i] = 0; m_cnt[d][i] = 0; m_ovf[d][i] = 0;
            end
    endtask

    // behavioural rules for one clock edge
    task automatic model_edge();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 4; i++) begin
                bit p = pk[d][i];
                bit c = cl[d][i];
                int mx = max_of(d);
                if (m_st[d][i] == 0) begin
                    if (p) begin m_st[d][i] = 1; m_cnt[d][i] = 0; end
                end else if (m_st[d][i] == 1) begin
                    if (!p) m_st[d][i] = 2;
                    else if (m_cnt[d][i] + 1 > mx) begin
                        if (OVF) m_ovf[d][i] = 1;
                        m_cnt[d][i] = (d == 2) ? mx : (m_cnt[d][i] + 1) % (mx + 1);
                    end else m_cnt[d][i] = m_cnt[d][i] + 1;
                end else begin
                    if (c) begin
                        m_st[d][i] = p ? 1 : 0; m_cnt[d][i] = 0; m_ovf[d][i] = 0;
                    end
                end
            end
    endtask

    task automatic check_all();
        for (int d = 0; d < 3; d++) begin
            int occ = 0;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("d%0d_cnt%0d", d, i), get_cnt(d, i), m_cnt[d][i]);
                chk($sformatf("d%0d_done%0d", d, i), int'(dn[d][i]), (m_st[d][i] == 2) ? 1 : 0);
                chk($sformatf("d%0d_ovf%0d", d, i), int'(ov[d][i]), int'(m_ovf[d][i]));
                if (m_st[d][i] == 1) occ++;
            end
            chk($sformatf("d%0d_occ", d), int'(oc[d]), occ);
        end
    endtask

    // one rising edge, model update, check 1 time unit later
    task automatic tick();
        @(posedge clk_1Hz);
        if (rst) model_reset(); else model_edge();
        #1;
        check_all();
    endtask

    task automatic set_all(input logic [3:0] p, input logic [3:0] c);
        for (int d = 0; d < 3; d++) begin pk[d] = p; cl[d] = c; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [3:0] parked;
        logic [3:0] clr;
        int exp_c0;
        int exp_w;
        int exp_s;
        int exp_done;
        int exp_occ;
    } vec_t;

    vec_t tbl [12];

    initial begin
        rst = 1'b1;
        set_all(4'h0, 4'h0);
        model_reset();
        #2;
        check_all();
        chk("reset_occ", int'(oc[0]), 0);
        #10;
        rst = 1'b0;

        // 10 edges parked, depart, then clear
        for (int r = 0; r < 10; r++)
            tbl[r] = '{4'h1, 4'h0, r, r % 6, (r > 5) ? 5 : r, 0, 1};
        tbl[10] = '{4'h0, 4'h0, 9, 3, 5, 1, 0};
        tbl[11] = '{4'h0, 4'h1, 0, 0, 0, 0, 0};

        for (int r = 0; r < 12; r++) begin
            set_all(tbl[r].parked, tbl[r].clr);
            tick();
            chk($sformatf("tbl%0d_c0", r), get_cnt(0, 0), tbl[r].exp_c0);
            chk($sformatf("tbl%0d_wrap", r), get_cnt(1, 0), tbl[r].exp_w);
            chk($sformatf("tbl%0d_sat", r), get_cnt(2, 0), tbl[r].exp_s);
            chk($sformatf("tbl%0d_done", r), int'(dn[0][0]), tbl[r].exp_done);
            chk($sformatf("tbl%0d_occ", r), int'(oc[0]), tbl[r].exp_occ);
            if (r == 10) begin
                chk("hold_ovf_default", int'(ov[0][0]), 0);
                chk("hold_ovf_wrap", int'(ov[1][0]), int'(OVF));
                chk("hold_ovf_sat", int'(ov[2][0]), int'(OVF));
            end
        end

        // space 2 frozen at 7, re-arrival ignored until clr
        do_reset();
        set_all(4'h4, 4'h0);
        repeat (8) tick();
        set_all(4'h0, 4'h0);
        tick();
        chk("s2_hold_cnt", get_cnt(0, 2), 7);
        set_all(4'h4, 4'h0);
        repeat (2) tick();
        chk("s2_rearrive_cnt", get_cnt(0, 2), 7);
        chk("s2_rearrive_done", int'(dn[0][2]), 1);
        chk("s2_rearrive_occ", int'(oc[0]), 0);
        set_all(4'h4, 4'h4);
        tick();
        chk("s2_clr_cnt", get_cnt(0, 2), 0);
        chk("s2_clr_done", int'(dn[0][2]), 0);
        chk("s2_clr_occ", int'(oc[0]), 1);

        // all four arrive together, one departs
        do_reset();
        set_all(4'hF, 4'h0);
        tick();
        chk("all_occ4", int'(oc[0]), 4);
        set_all(4'hB, 4'h0);
        tick();
        chk("one_left_occ3", int'(oc[0]), 3);

        // async reset mid-count on space 1
        do_reset();
        set_all(4'h2, 4'h0);
        repeat (124) tick();
        chk("s1_cnt123", get_cnt(0, 1), 123);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_cnt", int'(sc0), 0);
        chk("async_rst_occ", int'(oc[0]), 0);
        chk("async_rst_done", int'(dn[0]), 0);
        check_all();
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_cnt", get_cnt(0, 1), 0);
        chk("post_rst_occ", int'(oc[0]), 1);

        // randomized independent traffic on every instance
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 3; d++) begin
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 3) == 0) pk[d][i] = ~pk[d][i];
                    cl[d][i] = ($urandom_range(0, 2) == 0);
                end
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
